// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between the core's AXI master and the RAM slave.
// Payload widths are fixed at 32-bit data/address; only the ID width varies.
interface axi_ram_slave_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave RAM: one burst at a time, reads and writes share a single
// word-addressed memory, round-robin between AR and AW when both request.
//
// state | meaning
// IDLE  | waiting for an address handshake, arbitration happens here
// RD    | streaming read beats, rdata register holds the current beat
// WR    | accepting write beats until the counter reaches len
// WRESP | presenting the write response until bready
module axi_ram_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int ID_WIDTH   = 4
) (
    input logic            clk,
    input logic            rst,
    axi_ram_slave_if.slave s_axi
);
    // Only the word index plus the byte offset is kept; upper address bits alias.
    localparam int AW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t              r_state;
    logic                r_last_wr;
    logic [ID_WIDTH-1:0] r_id;
    logic [AW-1:0]       r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_cnt;
    logic [1:0]          r_burst;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [2**ADDR_WIDTH];

    logic                w_idle;
    logic                w_aw_grant;
    logic                w_ar_grant;
    logic                w_at_last;
    logic                w_w_beat;
    logic                w_r_beat;
    logic [AW-1:0]       w_next_addr;
    logic                w_unused;

    // WRAP masks with (len+1)*4-1, which is only a clean window for len 1/3/7/15.
    function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] addr,
                                                   input logic [7:0]    len,
                                                   input logic [1:0]    burst);
        logic [AW-1:0] mask;
        mask = AW'({len, 2'b11});
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + AW'(4)) & mask);
            default: return addr + AW'(4);
        endcase
    endfunction

    assign w_idle      = (r_state == IDLE);
    assign w_aw_grant  = w_idle && s_axi.awvalid && (!s_axi.arvalid || !r_last_wr);
    assign w_ar_grant  = w_idle && s_axi.arvalid && (!s_axi.awvalid || r_last_wr);
    assign w_at_last   = (r_cnt == r_len);
    assign w_w_beat    = (r_state == WR) && s_axi.wvalid;
    assign w_r_beat    = (r_state == RD) && s_axi.rready;
    assign w_next_addr = f_next_addr(r_addr, r_len, r_burst);

    assign s_axi.awready = w_aw_grant;
    assign s_axi.arready = w_ar_grant;
    assign s_axi.wready  = (r_state == WR);
    assign s_axi.bvalid  = (r_state == WRESP);
    assign s_axi.bid     = r_id;
    assign s_axi.bresp   = r_err ? 2'b10 : 2'b00;
    assign s_axi.rvalid  = (r_state == RD);
    assign s_axi.rid     = r_id;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rlast   = (r_state == RD) && w_at_last;

    assign w_unused = ^{s_axi.awaddr[31:AW], s_axi.araddr[31:AW],
                        s_axi.awsize, s_axi.arsize};

    // Burst sequencing: address capture, beat counting, read prefetch, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last_wr <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aw_grant) begin
                        r_state   <= WR;
                        r_last_wr <= 1'b1;
                        r_id      <= s_axi.awid;
                        r_addr    <= s_axi.awaddr[AW-1:0];
                        r_len     <= s_axi.awlen;
                        r_burst   <= s_axi.awburst;
                        r_cnt     <= 8'd0;
                    end else if (w_ar_grant) begin
                        r_state   <= RD;
                        r_last_wr <= 1'b0;
                        r_id      <= s_axi.arid;
                        r_addr    <= s_axi.araddr[AW-1:0];
                        r_len     <= s_axi.arlen;
                        r_burst   <= s_axi.arburst;
                        r_cnt     <= 8'd0;
                        r_rdata   <= r_mem[s_axi.araddr[AW-1:2]];
                    end
                end
                RD: begin
                    if (w_r_beat) begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_addr  <= w_next_addr;
                        r_rdata <= r_mem[w_next_addr[AW-1:2]];
                        if (w_at_last) r_state <= IDLE;
                    end
                end
                WR: begin
                    if (w_w_beat) begin
                        if (s_axi.wlast != w_at_last) r_err <= 1'b1;
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= w_next_addr;
                        if (w_at_last) r_state <= WRESP;
                    end
                end
                WRESP: begin
                    if (s_axi.bready) begin
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Byte-lane RAM writes; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_w_beat && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (s_axi.wstrb[i]) r_mem[r_addr[AW-1:2]][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

Synthesizable AXI4 slave memory that terminates the 32-bit AXI bus driven by the core's AXI master (instruction, data and D-cache refill/writeback traffic). It replaces the vendor block-memory AXI slave in simulation and small on-chip configurations. It services one burst at a time, either read or write, from a single word-addressed RAM. Arbitration between reads and writes is round-robin.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-index bits; RAM holds 2^ADDR_WIDTH 32-bit words.
- ID_WIDTH, 4, AXI ID width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axi_awid / awaddr / awlen / awsize / awburst  in  ID_WIDTH/32/8/3/2  write address channel payload.
- s_axi_awvalid  in  1;  s_axi_awready  out  1.
- s_axi_wdata / wstrb / wlast  in  32/4/1  write data payload.
- s_axi_wvalid  in  1;  s_axi_wready  out  1.
- s_axi_bid / bresp  out  ID_WIDTH/2  write response payload.
- s_axi_bvalid  out  1;  s_axi_bready  in  1.
- s_axi_arid / araddr / arlen / arsize / arburst  in  ID_WIDTH/32/8/3/2  read address channel payload.
- s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rid / rdata / rresp / rlast  out  ID_WIDTH/32/2/1  read data payload.
- s_axi_rvalid  out  1;  s_axi_rready  in  1.

## Operation
- FSM states: IDLE, RD, WR, WRESP.
- IDLE, only arvalid high: arready=1, handshake, go to RD.
- IDLE, only awvalid high: awready=1, handshake, go to WR.
- IDLE, both high: grant goes to the channel not granted last (flag last_wr, reset 0), so after reset a write wins. The other ready stays 0.
- Address handshake latches ID, address, len and burst into registers, plus a beat counter (8b, cleared to 0).
- Word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so accesses alias modulo RAM size. addr[1:0] is ignored.
- awsize/arsize are ignored; every beat is 4 bytes.
- Next address per burst type:
  - FIXED (00): unchanged.
  - INCR (01): +4.
  - WRAP (10): +4, wrapping within a (len+1)*4-byte aligned window; len must be 1, 3, 7 or 15.
  - Reserved (11): handled as INCR.
- RD:
  - rdata register is loaded with mem[index] on the AR handshake and reloaded with mem[next index] on every accepted beat.
  - rvalid=1 throughout RD. rlast=1 iff beat counter == len.
  - rresp=00; rid = latched ID.
  - On rvalid&&rready: counter+1, address advances. If that beat had rlast, go to IDLE.
- WR:
  - wready=1.
  - Each wvalid&&wready writes the bytes enabled by wstrb[i] (byte i = wdata[8i+7:8i]) to mem[index], then counter+1 and the address advances.
  - The burst ends on the beat where counter == len, regardless of wlast; go to WRESP.
  - If any beat's wlast differs from (counter == len), a sticky error flag is set.
- WRESP: bvalid=1; bid = latched ID; bresp=10 (SLVERR) if the error flag is set, else 00. On bready, clear the flag and go to IDLE.
- RAM contents are not reset. Contents written before a reset survive it.

## Timing
- Reset values: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=00, rresp=00, state IDLE, last_wr=0.
- awready/arready are combinational from state, valids and last_wr, and are 0 outside IDLE.
- Read latency: AR handshake in cycle N gives first rvalid in N+1. Beats are back-to-back while rready=1.
- rvalid stall: rdata, rlast and rid are held stable while rvalid&&!rready.
- Write: AW handshake in cycle N gives wready in N+1. bvalid comes in the cycle after the last W beat.
- bvalid is held until bready. The next address handshake happens no earlier than the cycle after the B or last-R handshake, so minimum turnaround is one idle cycle.
- Reset asserted mid-burst: next cycle is IDLE with all valids/readies 0. The burst is abandoned with no response. Write beats already accepted remain in the RAM.
- len=0: single beat, rlast on the first beat; a write goes straight to WRESP after one beat.
- len=255 INCR is supported; the counter does not overflow.

## Test plan
- Single write 0x10 ← 0x00000001 (wstrb=F, len=0, id=3) gives bid=3, bresp=00. Read 0x10 then gives rdata=0x00000001, rid=3, rlast=1.
- INCR len=3 write at 0x110 of CCCCCCCC, DDDDDDDD, EEEEEEEE, FFFFFFFF; INCR len=3 read back returns the same order, with rlast only on beat 4.
- WRAP len=3 read at 0x118 of the same data returns EEEEEEEE, FFFFFFFF, CCCCCCCC, DDDDDDDD.
- Partial strobe: 0x200 holds 0x12345678; writing 0xAAAAAAAA with wstrb=0011 leaves read-back 0x1234AAAA.
- AW and AR asserted in the same cycle right after reset: the write (0x20 ← 0xA) is granted first and the read of 0x20 then returns 0xA. A second simultaneous pair grants the read first.
- rready toggled 1,0,0,1 during a 4-beat read: rdata is stable while stalled and no beat is lost or duplicated. A len=1 write with wlast on beat 1 gives both beats written and bresp=10.
